// File: rtl/cksum_sched_if.sv
// Control/result bundle between requesters, the checksum scheduler and the shared cksum engine.
// The slave view belongs to the scheduler; the master view belongs to its environment.
interface cksum_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int LEN_W   = 8
);
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*ADDR_W-1:0] req_start_i;
  logic [NUM_REQ*LEN_W-1:0]  req_len_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic [NUM_REQ-1:0]        done_o;
  logic                      err_o;
  logic [15:0]               val_o;
  logic                      eng_start_o;
  logic [ADDR_W-1:0]         eng_field_start_o;
  logic [LEN_W-1:0]          eng_field_len_o;
  logic [15:0]               eng_val_i;
  logic                      eng_ready_i;

  modport slave (
    input  req_i, req_start_i, req_len_i, eng_val_i, eng_ready_i,
    output gnt_o, done_o, err_o, val_o, eng_start_o, eng_field_start_o, eng_field_len_o
  );

  modport master (
    output req_i, req_start_i, req_len_i, eng_val_i, eng_ready_i,
    input  gnt_o, done_o, err_o, val_o, eng_start_o, eng_field_start_o, eng_field_len_o
  );
endinterface

// File: rtl/cksum_sched.sv
// Round-robin scheduler sharing one Internet-checksum engine among NUM_REQ requesters.
// Odd-length fields are rejected without touching the engine; a stuck engine times out.
module cksum_sched #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  cksum_sched_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state, next_state;
  logic [PTR_W-1:0]   ptr, win, cand, ptr_next;
  logic               found;
  logic [NUM_REQ-1:0] gnt, done;
  logic [ADDR_W-1:0]  field_start, sel_start;
  logic [LEN_W-1:0]   field_len, sel_len;
  logic [15:0]        val;
  logic               err, eng_start;
  logic [CNT_W-1:0]   cnt;

  // Scan from the pointer, wrapping, so the first pending requester after the last winner wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(ptr) + i >= NUM_REQ)
        cand = PTR_W'(int'(ptr) + i - NUM_REQ);
      else
        cand = PTR_W'(int'(ptr) + i);
      if (!found && bus.req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    sel_start = '0;
    sel_len   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == PTR_W'(i)) begin
        sel_start = bus.req_start_i[i*ADDR_W +: ADDR_W];
        sel_len   = bus.req_len_i[i*LEN_W +: LEN_W];
      end
    end
  end

  assign ptr_next = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    eng_start  = 1'b0;
    done       = '0;
    case (state)
      IDLE:  if (found) next_state = sel_len[0] ? DONE : ISSUE;
      ISSUE: begin
        eng_start  = 1'b1;
        next_state = WAIT;
      end
      WAIT:  if (bus.eng_ready_i || cnt == CNT_W'(TIMEOUT)) next_state = DONE;
      DONE:  begin
        done       = gnt;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Ready wins over timeout when both hit in the same cycle; a timeout leaves val untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr         <= '0;
      gnt         <= '0;
      field_start <= '0;
      field_len   <= '0;
      val         <= '0;
      err         <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          gnt         <= NUM_REQ'(1) << win;
          field_start <= sel_start;
          field_len   <= sel_len;
          ptr         <= ptr_next;
          err         <= sel_len[0];
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (bus.eng_ready_i)               val <= bus.eng_val_i;
          else if (cnt == CNT_W'(TIMEOUT))   err <= 1'b1;
          else                               cnt <= cnt + 1'b1;
        end
        DONE: begin
          gnt <= '0;
          err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt_o             = gnt;
  assign bus.done_o            = done;
  assign bus.err_o             = err;
  assign bus.val_o             = val;
  assign bus.eng_start_o       = eng_start;
  assign bus.eng_field_start_o = field_start;
  assign bus.eng_field_len_o   = field_len;
endmodule

// File: tb/tb_cksum_sched.sv
// Directed bench for cksum_sched with a behavioural checksum engine (ready after len/2+3 edges).
// Expected results are hand-computed over the sample IPv4 header.
module tb_cksum_sched;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 8;
  localparam int LEN_W   = 8;
  localparam logic [159:0] HDR = 160'h4500_0073_0000_4000_4011_0000_C0A8_0001_C0A8_00C7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   n;
  int   early;

  logic        hang = 1'b0;
  logic        eng_busy = 1'b0;
  logic        eng_ready = 1'b0;
  logic [15:0] eng_val = '0;
  logic [15:0] eng_res = '0;
  int          eng_rem = 0;

  cksum_sched_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  cksum_sched #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] hdrByte(int a);
    logic [159:0] h;
    h = HDR;
    if (a < 0 || a >= 20) return 8'h00;
    return h[159 - 8*a -: 8];
  endfunction

  function automatic logic [15:0] engineSum(int s, int len);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < len; i += 2) acc += {16'h0, hdrByte(s + i), hdrByte(s + i + 1)};
    acc = {16'h0, acc[15:0]} + {16'h0, acc[31:16]};
    acc = {16'h0, acc[15:0]} + {16'h0, acc[31:16]};
    return ~acc[15:0];
  endfunction

  // Engine model: ready is sticky, cleared when start is accepted; hang keeps it low forever.
  always @(posedge clk) begin
    if (!rst) begin
      eng_ready <= 1'b0;
      eng_busy  <= 1'b0;
      eng_rem   <= 0;
      eng_val   <= '0;
    end else if (bus.eng_start_o) begin
      eng_ready <= 1'b0;
      eng_busy  <= 1'b1;
      eng_rem   <= int'(bus.eng_field_len_o) / 2 + 3;
      eng_res   <= engineSum(int'(bus.eng_field_start_o), int'(bus.eng_field_len_o));
    end else if (eng_busy && !hang) begin
      if (eng_rem == 1) begin
        eng_ready <= 1'b1;
        eng_busy  <= 1'b0;
        eng_val   <= eng_res;
      end else begin
        eng_rem <= eng_rem - 1;
      end
    end
  end

  assign bus.eng_ready_i = eng_ready;
  assign bus.eng_val_i   = eng_val;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [7:0] start, input logic [7:0] len);
    bus.req_start_i[idx*ADDR_W +: ADDR_W] = start;
    bus.req_len_i[idx*LEN_W +: LEN_W]     = len;
    bus.req_i[idx]                        = 1'b1;
  endtask

  task automatic dropReq(input int idx);
    bus.req_i[idx] = 1'b0;
  endtask

  // Advances at least one cycle, then until done_o is seen or the limit expires.
  task automatic waitDone(input int limit, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (bus.done_o == '0 && cycles < limit);
  endtask

  task automatic doReset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    bus.req_i       = '0;
    bus.req_start_i = '0;
    bus.req_len_i   = '0;

    rst = 1'b0;
    tick();
    tick();
    checkOutput("reset_gnt", 32'(bus.gnt_o), 32'h0);
    checkOutput("reset_done", 32'(bus.done_o), 32'h0);
    checkOutput("reset_err", 32'(bus.err_o), 32'h0);
    checkOutput("reset_val", 32'(bus.val_o), 32'h0);
    checkOutput("reset_start", 32'(bus.eng_start_o), 32'h0);
    rst = 1'b1;
    tick();

    $display("[TB] single request, IPv4 header");
    applyStimulus(0, 8'd0, 8'd20);
    tick();
    checkOutput("single_gnt", 32'(bus.gnt_o), 32'h1);
    checkOutput("single_eng_start", 32'(bus.eng_start_o), 32'h1);
    checkOutput("single_field_len", 32'(bus.eng_field_len_o), 32'd20);
    tick();
    checkOutput("single_start_pulse", 32'(bus.eng_start_o), 32'h0);
    waitDone(40, n);
    checkOutput("single_latency", 32'(n + 2), 32'd16);
    checkOutput("single_done", 32'(bus.done_o), 32'h1);
    checkOutput("single_val", 32'(bus.val_o), 32'hB861);
    checkOutput("single_err", 32'(bus.err_o), 32'h0);
    dropReq(0);
    tick();
    checkOutput("single_done_clear", 32'(bus.done_o), 32'h0);
    checkOutput("single_gnt_clear", 32'(bus.gnt_o), 32'h0);

    $display("[TB] four simultaneous requests");
    doReset();
    applyStimulus(0, 8'd0, 8'd2);
    applyStimulus(1, 8'd0, 8'd4);
    applyStimulus(2, 8'd0, 8'd6);
    applyStimulus(3, 8'd0, 8'd8);
    waitDone(40, n);
    checkOutput("rr0_latency", 32'(n), 32'd7);
    checkOutput("rr0_done", 32'(bus.done_o), 32'h1);
    checkOutput("rr0_val", 32'(bus.val_o), 32'hBAFF);
    dropReq(0);
    waitDone(40, n);
    checkOutput("rr1_latency", 32'(n), 32'd9);
    checkOutput("rr1_done", 32'(bus.done_o), 32'h2);
    checkOutput("rr1_val", 32'(bus.val_o), 32'hBA8C);
    dropReq(1);
    waitDone(40, n);
    checkOutput("rr2_latency", 32'(n), 32'd10);
    checkOutput("rr2_done", 32'(bus.done_o), 32'h4);
    checkOutput("rr2_val", 32'(bus.val_o), 32'hBA8C);
    dropReq(2);
    waitDone(40, n);
    checkOutput("rr3_latency", 32'(n), 32'd11);
    checkOutput("rr3_done", 32'(bus.done_o), 32'h8);
    checkOutput("rr3_val", 32'(bus.val_o), 32'h7A8C);
    checkOutput("rr3_err", 32'(bus.err_o), 32'h0);
    dropReq(3);
    tick();

    $display("[TB] fairness req0 vs held req2");
    applyStimulus(0, 8'd0, 8'd2);
    applyStimulus(2, 8'd0, 8'd2);
    waitDone(40, n);
    checkOutput("fair_a_done", 32'(bus.done_o), 32'h1);
    dropReq(0);
    tick();
    applyStimulus(0, 8'd0, 8'd2);
    waitDone(40, n);
    checkOutput("fair_b_done", 32'(bus.done_o), 32'h4);
    waitDone(40, n);
    checkOutput("fair_c_done", 32'(bus.done_o), 32'h1);
    dropReq(0);
    tick();
    applyStimulus(0, 8'd0, 8'd2);
    waitDone(40, n);
    checkOutput("fair_d_done", 32'(bus.done_o), 32'h4);
    dropReq(0);
    dropReq(2);
    tick();

    $display("[TB] odd length reject");
    applyStimulus(1, 8'd0, 8'd5);
    tick();
    checkOutput("odd_done", 32'(bus.done_o), 32'h2);
    checkOutput("odd_err", 32'(bus.err_o), 32'h1);
    checkOutput("odd_no_start", 32'(bus.eng_start_o), 32'h0);
    checkOutput("odd_val_held", 32'(bus.val_o), 32'hBAFF);
    dropReq(1);
    tick();
    checkOutput("odd_done_clear", 32'(bus.done_o), 32'h0);
    checkOutput("odd_err_clear", 32'(bus.err_o), 32'h0);
    checkOutput("odd_no_start2", 32'(bus.eng_start_o), 32'h0);

    $display("[TB] engine timeout");
    hang = 1'b1;
    applyStimulus(2, 8'd0, 8'd4);
    tick();
    checkOutput("to_issue", 32'(bus.eng_start_o), 32'h1);
    waitDone(60, n);
    checkOutput("to_latency", 32'(n), 32'd17);
    checkOutput("to_done", 32'(bus.done_o), 32'h4);
    checkOutput("to_err", 32'(bus.err_o), 32'h1);
    checkOutput("to_val_held", 32'(bus.val_o), 32'hBAFF);
    dropReq(2);
    hang = 1'b0;
    tick();
    applyStimulus(3, 8'd0, 8'd0);
    waitDone(40, n);
    checkOutput("len0_latency", 32'(n), 32'd6);
    checkOutput("len0_done", 32'(bus.done_o), 32'h8);
    checkOutput("len0_val", 32'(bus.val_o), 32'hFFFF);
    checkOutput("len0_err", 32'(bus.err_o), 32'h0);
    dropReq(3);
    tick();

    $display("[TB] reset during WAIT");
    applyStimulus(1, 8'd0, 8'd20);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b0;
    dropReq(1);
    tick();
    checkOutput("rstw_gnt", 32'(bus.gnt_o), 32'h0);
    checkOutput("rstw_done", 32'(bus.done_o), 32'h0);
    checkOutput("rstw_err", 32'(bus.err_o), 32'h0);
    checkOutput("rstw_val", 32'(bus.val_o), 32'h0);
    checkOutput("rstw_start", 32'(bus.eng_start_o), 32'h0);
    checkOutput("rstw_field_len", 32'(bus.eng_field_len_o), 32'h0);
    rst = 1'b1;
    early = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done_o != '0) early++;
    end
    checkOutput("rstw_no_done", 32'(early), 32'h0);
    applyStimulus(3, 8'd2, 8'd2);
    tick();
    checkOutput("rstw_req3_gnt", 32'(bus.gnt_o), 32'h8);
    waitDone(40, n);
    checkOutput("rstw_req3_latency", 32'(n), 32'd6);
    checkOutput("rstw_req3_done", 32'(bus.done_o), 32'h8);
    checkOutput("rstw_req3_val", 32'(bus.val_o), 32'hFF8C);
    dropReq(3);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cksum_sched.md
# cksum_sched

Round-robin scheduler that shares the single `cksum` engine among `NUM_REQ` requesters, e.g. parser and deparser stages that each need an Internet checksum over a field of the shared header buffer. It latches one requester's field window, pulses the engine's start, waits for the engine's sticky ready, and returns the 16-bit result with a one-cycle done pulse to the granted requester. The header bus itself is routed outside this block; only control and result pass through it.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ADDR_W`, default 8: field start address width.
- `LEN_W`, default 8: field length width, in bytes.
- `TIMEOUT`, default 255: maximum WAIT cycles before an engine fault is declared.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-low reset (reset when `rst`==0).
- `req_i` in NUM_REQ: per-requester request level.
- `req_start_i` in NUM_REQ×ADDR_W: per-requester field start byte address.
- `req_len_i` in NUM_REQ×LEN_W: per-requester field length in bytes.
- `gnt_o` out NUM_REQ: one-hot grant, held from ISSUE through DONE.
- `done_o` out NUM_REQ: one-hot, one-cycle completion pulse.
- `err_o` out 1: qualifies `done_o`. 1 means odd length or timeout, and the result is invalid.
- `val_o` out 16: checksum result, valid while `done_o`≠0 and holding its last value otherwise.
- `eng_start_o` out 1: engine start pulse.
- `eng_field_start_o` out ADDR_W: field start address to the engine.
- `eng_field_len_o` out LEN_W: field length to the engine.
- `eng_val_i` in 16: engine result (low half of engine value).
- `eng_ready_i` in 1: engine ready. It is a sticky level, cleared by the engine on the edge that accepts start.

## Operation
- States are IDLE, ISSUE, WAIT and DONE. On reset: state IDLE, round-robin pointer 0, all outputs 0.
- **IDLE, arbitration:** scan `req_i` starting at the pointer index and wrapping modulo NUM_REQ. The first set bit wins.
  - On a win, register the winner's start and length into the `eng_field_*` registers and set `gnt_o`.
  - Set pointer = winner+1 (mod NUM_REQ).
  - If the length is even, go to ISSUE. If the length is odd, go to DONE with `err_o`=1 and no engine access.
  - If no request is pending, stay in IDLE.
- **ISSUE:** drive `eng_start_o`=1 for exactly this cycle, clear the timeout counter, go to WAIT.
- **WAIT:** `eng_start_o`=0. Each cycle:
  - If `eng_ready_i`=1, capture `eng_val_i` into `val_o` and go to DONE with `err_o`=0.
  - Otherwise, if the counter equals TIMEOUT, go to DONE with `err_o`=1 and leave `val_o` unchanged.
  - Otherwise increment the counter.
- **DONE:** `done_o`=`gnt_o` for one cycle, `err_o` valid. Then clear `gnt_o` and `err_o` and return to IDLE.
- Requester protocol:
  - Hold `req_i` and the field inputs stable until `done_o`, then drop `req_i` on the next cycle.
  - Field inputs are sampled only at the grant edge; later changes are ignored.
  - Dropping `req_i` while granted does not abort the transaction; done is still pulsed.
- Length 0 is legal. The engine returns ~0 = 0xFFFF.
- The engine always sees a start only in its idle state: WAIT is left only after ready rises, and ready rises on the engine's return-to-idle edge.
- After a timeout the block resumes normal arbitration. Recovering a hung engine is a system-level reset matter.

## Timing
- With the engine timing (start accepted at edge E, ready high after E + len/2 + 3 edges), request to done is len/2 + 6 cycles:
  - cycle 0: IDLE samples `req_i`;
  - cycle 1: ISSUE;
  - cycles 2 .. len/2+4: WAIT;
  - cycle len/2+5: WAIT sees ready;
  - cycle len/2+6: DONE.
- Odd-length reject: done/err asserted in cycle 1.
- Back-to-back: the next grant is sampled in the IDLE cycle after DONE, so there is 1 idle cycle between transactions.
- Simultaneous requests: at most one grant per IDLE cycle; the others wait their round-robin turn. Worst-case wait is NUM_REQ−1 transactions.
- A requester whose `done_o` coincides with a new `req_i` assertion is serviced only when the pointer reaches it again.
- Reset asserted mid-transaction returns to IDLE next edge with all outputs 0. No `done_o` is emitted for the aborted transaction. The engine is reset by the same `rst`.

## Test plan
- Single request, req0 start=0 len=20, engine model summing header 4500 0073 0000 4000 4011 0000 C0A8 0001 C0A8 00C7 -> gnt_o=0001; eng_start_o high in cycle 1; done_o=0001 with val_o=0xB861, err_o=0 in cycle 16.
- All four requesters assert together (len 2, 4, 6, 8) -> grants in order 0,1,2,3; each done pulse lands on the matching bit; the pointer wraps back to 0.
- Fairness: req0 re-asserts immediately after each done while req2 is held -> grants alternate 0,2,0,2.
- Odd length: req1 len=5 -> done_o=0010 and err_o=1 in cycle 1; eng_start_o never asserted; val_o unchanged.
- Timeout: engine model never raises ready, TIMEOUT=15 -> done_o plus err_o exactly 17 cycles after ISSUE; the next request is granted normally.
- Reset in WAIT, then release -> all outputs 0; no done_o; a fresh req3 is granted first, since the pointer is back at 0 and req3 is the only request.
